// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: single-outstanding instruction fetch FSM feeding a flushable instruction FIFO
module ifu_fetch_ctrl #(
    parameter logic [31:0] RST_PC = 32'h8000_0000,
    parameter int ADDR_LEN = 32,
    parameter int INST_LEN = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic [ADDR_LEN-1:0]          redirect_pc_i,
    output logic [ADDR_LEN-1:0]          araddr_o,
    output logic                         arvalid_o,
    input  logic                         arready_i,
    input  logic                         rvalid_i,
    input  logic [INST_LEN-1:0]          rdata_i,
    input  logic [1:0]                   rresp_i,
    output logic                         rready_o,
    input  logic                         fifo_full_i,
    output logic                         fifo_wen_o,
    output logic [ADDR_LEN+INST_LEN:0]   fifo_wdata_o
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
    state_t                     state_q, state_d;
    logic [ADDR_LEN-1:0]        pc_q, pc_d, stale_q, stale_d;
    logic                       drop_q, drop_d;
    logic [ADDR_LEN+INST_LEN:0] hold_q, hold_d;
    logic [ADDR_LEN+INST_LEN:0] resp_word;
    logic [ADDR_LEN-1:0]        pc_inc;
    assign resp_word    = {rresp_i != 2'b00, pc_q, rdata_i};
    assign pc_inc       = pc_q + ADDR_LEN'(4);
    // a request flushed before its handshake keeps presenting the stale address
    assign araddr_o     = drop_q ? stale_q : pc_q;
    assign arvalid_o    = state_q == S_REQ;
    assign rready_o     = state_q == S_WAIT;
    assign fifo_wdata_o = state_q == S_HOLD ? hold_q : resp_word;
    // state, pc, drop flag and hold register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= ADDR_LEN'(RST_PC);
            stale_q <= ADDR_LEN'(RST_PC);
            drop_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stale_q <= stale_d;
            drop_q  <= drop_d;
            hold_q  <= hold_d;
        end
    end
    // next-state, redirect handling and FIFO push
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        stale_d    = stale_q;
        drop_d     = drop_q;
        hold_d     = hold_q;
        fifo_wen_o = 1'b0;
        case (state_q)
            S_REQ: begin
                if (flush_i) begin
                    pc_d   = redirect_pc_i;
                    drop_d = 1'b1;
                    if (!arready_i) stale_d = araddr_o;
                end
                if (arready_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rvalid_i) begin
                    if (flush_i || drop_q) begin
                        state_d = S_REQ;
                        drop_d  = 1'b0;
                    end else if (!fifo_full_i) begin
                        fifo_wen_o = 1'b1;
                        pc_d       = pc_inc;
                        state_d    = S_REQ;
                    end else begin
                        hold_d  = resp_word;
                        state_d = S_HOLD;
                    end
                end
                if (flush_i) begin
                    pc_d = redirect_pc_i;
                    if (!rvalid_i) drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (flush_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = S_REQ;
                end else if (!fifo_full_i) begin
                    fifo_wen_o = 1'b1;
                    pc_d       = pc_inc;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end
endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// tb_ifu_fetch_ctrl: directed checks of fetch handshakes, FIFO backpressure, flush and wrap
module tb_ifu_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst, flush, arvalid, arready, rvalid, rready, full, wen;
    logic [31:0] rpc, araddr, rdata;
    logic [1:0]  rresp;
    logic [64:0] wdata;
    int          n_run = 0, n_fail = 0;

    ifu_fetch_ctrl dut (
        .clk(clk), .rst(rst), .flush_i(flush), .redirect_pc_i(rpc),
        .araddr_o(araddr), .arvalid_o(arvalid), .arready_i(arready),
        .rvalid_i(rvalid), .rdata_i(rdata), .rresp_i(rresp), .rready_o(rready),
        .fifo_full_i(full), .fifo_wen_o(wen), .fifo_wdata_o(wdata)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic r, input logic f, input logic [31:0] p, input logic ar,
                       input logic rv, input logic [31:0] d, input logic [1:0] rs, input logic fl);
        @(negedge clk);
        rst = r; flush = f; rpc = p; arready = ar; rvalid = rv; rdata = d; rresp = rs; full = fl;
        #1;
    endtask

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        // first cycle out of reset, request accepted immediately
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        chk("rst_arvalid", arvalid, 1);
        chk("rst_araddr", araddr, 32'h8000_0000);
        chk("rst_rready", rready, 0);
        chk("rst_wen", wen, 0);
        cyc(0, 0, 0, 0, 1, 32'h0000_0413, 0, 0);
        chk("p1_rready", rready, 1);
        chk("p1_wen", wen, 1);
        chk("p1_wdata", wdata, {1'b0, 32'h8000_0000, 32'h0000_0413});
        // backpressure: response lands while FIFO full
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        chk("p2_araddr", araddr, 32'h8000_0004);
        chk("p2_arvalid", arvalid, 1);
        cyc(0, 0, 0, 0, 1, 32'h0000_AAAA, 0, 1);
        chk("full_wen", wen, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("hold_wen", wen, 0);
        chk("hold_arvalid", arvalid, 0);
        chk("hold_rready", rready, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("hold_push", wen, 1);
        chk("hold_wdata", wdata, {1'b0, 32'h8000_0004, 32'h0000_AAAA});
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        chk("hold_nodup", wen, 0);
        chk("hold_next", araddr, 32'h8000_0008);
        // flush in WAIT
        cyc(0, 1, 32'h8000_0100, 0, 0, 0, 0, 0);
        chk("fw_wen", wen, 0);
        cyc(0, 0, 0, 0, 1, 32'h0000_0BAD, 0, 0);
        chk("fw_drop_wen", wen, 0);
        chk("fw_drop_rready", rready, 1);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        chk("fw_araddr", araddr, 32'h8000_0100);
        cyc(0, 0, 0, 0, 1, 32'h0000_0123, 0, 0);
        chk("fw_push", wen, 1);
        chk("fw_wdata", wdata, {1'b0, 32'h8000_0100, 32'h0000_0123});
        // flush in REQ before handshake: address must stay stable
        cyc(0, 1, 32'h8000_0100, 0, 0, 0, 0, 0);
        chk("fr_addr0", araddr, 32'h8000_0104);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("fr_addr1", araddr, 32'h8000_0104);
        chk("fr_arvalid", arvalid, 1);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        chk("fr_addr2", araddr, 32'h8000_0104);
        cyc(0, 0, 0, 0, 1, 32'h0000_0BAD, 0, 0);
        chk("fr_drop", wen, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        chk("fr_newaddr", araddr, 32'h8000_0100);
        chk("fr_arvalid2", arvalid, 1);
        // faulting response
        cyc(0, 0, 0, 0, 1, 32'h0000_DEAD, 2'b10, 0);
        chk("fault_wen", wen, 1);
        chk("fault_wdata", wdata, {1'b1, 32'h8000_0100, 32'h0000_DEAD});
        // flush coincident with handshake, redirect to wrap boundary
        cyc(0, 1, 32'hFFFF_FFFC, 1, 0, 0, 0, 0);
        chk("fault_next", araddr, 32'h8000_0104);
        cyc(0, 0, 0, 0, 1, 32'h0000_0BAD, 0, 0);
        chk("fh_drop", wen, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        chk("wrap_addr", araddr, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 1, 32'h0000_0077, 0, 0);
        chk("wrap_wdata", wdata, {1'b0, 32'hFFFF_FFFC, 32'h0000_0077});
        chk("wrap_wen", wen, 1);
        // flush in HOLD
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        chk("wrap_next", araddr, 32'h0000_0000);
        cyc(0, 0, 0, 0, 1, 32'h0000_0055, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("fhold_wen0", wen, 0);
        cyc(0, 1, 32'h8000_0200, 0, 0, 0, 0, 0);
        chk("fhold_flush_wen", wen, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        chk("fhold_addr", araddr, 32'h8000_0200);
        chk("fhold_arvalid", arvalid, 1);
        // flush in the same cycle as rvalid
        cyc(0, 1, 32'h8000_0300, 0, 1, 32'h0000_0BAD, 0, 0);
        chk("frv_wen", wen, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        chk("frv_addr", araddr, 32'h8000_0300);
        chk("frv_arvalid", arvalid, 1);
        // reset mid-transaction
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mrst_addr", araddr, 32'h8000_0000);
        chk("mrst_arvalid", arvalid, 1);
        chk("mrst_rready", rready, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/ifu_fetch_ctrl.md
IFU_FETCH_CTRL -- requirements
Module: ifu_fetch_ctrl

Interface
REQ-001 Parameter RST_PC, 32'h8000_0000, first fetch address after reset.
REQ-002 Parameter ADDR_LEN, 32, PC/address width.
REQ-003 Parameter INST_LEN, 32, instruction word width.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 flush  in  1  pipeline redirect strobe, one cycle.
REQ-007 redirect_pc  in  ADDR_LEN  new fetch PC, sampled when flush=1.
REQ-008 araddr  out  ADDR_LEN  read request address.
REQ-009 arvalid  out  1  read request valid.
REQ-010 arready  in  1  read request accepted.
REQ-011 rvalid  in  1  read response valid.
REQ-012 rdata  in  INST_LEN  read response data.
REQ-013 rresp  in  2  response status; nonzero = access fault.
REQ-014 rready  out  1  response accept.
REQ-015 fifo_full  in  1  full flag of the downstream flushable instruction FIFO.
REQ-016 fifo_wen  out  1  FIFO write strobe (drives the FIFO write-enable).
REQ-017 fifo_wdata  out  1+ADDR_LEN+INST_LEN  {fault, pc, inst} pushed into the FIFO.

Function
REQ-018 FSM states: REQ (arvalid=1), WAIT (rready=1), HOLD (response captured, waiting for FIFO space).
REQ-019 Single outstanding request; a new request is issued only after the previous response is pushed or dropped.
REQ-020 REQ: arvalid=1, araddr=pc; arvalid and araddr stay stable until arvalid&arready; on handshake go to WAIT.
REQ-021 WAIT: rready=1; on rvalid, if fifo_full=0 and no drop, assert fifo_wen combinationally that cycle, pc<=pc+4, go to REQ.
REQ-022 WAIT with rvalid and fifo_full=1: capture {fault,pc,rdata} into a hold register, go to HOLD; fifo_wen=0.
REQ-023 HOLD: fifo_wen=!fifo_full; on push, pc<=pc+4, go to REQ.
REQ-024 fault bit = (rresp!=2'b00); a faulting word is still pushed, and fetch continues at pc+4.
REQ-025 fifo_wen is never asserted while fifo_full=1 or flush=1.
REQ-026 Flush in REQ before handshake: pc<=redirect_pc, drop flag set, arvalid/araddr unchanged (AXI stability); the stale response is discarded.
REQ-027 Flush in REQ in the same cycle as arready: drop flag set, pc<=redirect_pc, go to WAIT.
REQ-028 Flush in WAIT, including the same cycle as rvalid: response discarded (no push), drop flag set unless rvalid is present that cycle, pc<=redirect_pc.
REQ-029 Flush in HOLD: hold register discarded, pc<=redirect_pc, go to REQ next cycle.
REQ-030 A response arriving with the drop flag set is accepted (rready=1) and discarded; drop flag clears; FSM goes to REQ with araddr=redirected pc.
REQ-031 Dropped request cycle: a REQ under the drop flag completes its handshake at the stale address; the FSM then returns to REQ with the new pc after the discard.
REQ-032 A second flush before the drop completes overwrites pc; one drop flag covers it (single outstanding).
REQ-033 PC arithmetic is modulo 2^ADDR_LEN; 32'hFFFF_FFFC+4 wraps to 0.
REQ-034 Peak throughput: one instruction per 2 cycles with arready and rvalid at zero latency.

Reset
REQ-035 While rst=1 at posedge: pc<=RST_PC, state<=REQ, drop<=0, hold register cleared.
REQ-036 The cycle after reset: arvalid=1, araddr=RST_PC, rready=0, fifo_wen=0.
REQ-037 Reset mid-transaction abandons any outstanding request without waiting; the environment also resets the memory side.

Verification
REQ-038 Reset, arready=1, rvalid one cycle later with rdata=32'h00000413 -> fifo_wdata={0,32'h80000000,32'h00000413}, fifo_wen=1, next araddr=32'h80000004.
REQ-039 fifo_full=1 when the response arrives -> no push, data held; fifo_full drops 3 cycles later -> one push of the held word, no duplicate.
REQ-040 flush with redirect_pc=32'h80000100 while in WAIT -> stale response discarded, next araddr=32'h80000100, first push pc=32'h80000100.
REQ-041 flush while arvalid=1 and arready=0 -> araddr stays at the old pc until accepted; its response is dropped; the following request is 32'h80000100.
REQ-042 rresp=2'b10 on a response -> pushed with fault=1, next araddr=pc+4.
REQ-043 pc=32'hFFFFFFFC fetch completes -> next araddr=32'h00000000.
